// File: rtl/vblank_access_arbiter.sv
// Round-robin arbiter granting the shared display-update resource only inside vertical blanking.
// Define VBLANK_ARB_TIMEOUT_EN to enable the per-burst timeout and the remaining-budget check.
module vblank_access_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 1024,
  parameter int VBLANK_CYCLES = 29000,
  parameter int GAP_CYCLES    = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             overrun_clr,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             window,
  output logic             frame_tick,
  output logic             overrun,
  output logic [2:0]       overrun_id
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_vblnk_s, r_vblnk_d;
  logic [PW-1:0]    r_ptr, r_owner, w_win, w_idx;
  logic [GW-1:0]    r_gap;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy, r_window, r_tick, r_overrun;
  logic [2:0]       r_ov_id;
  logic             w_rise, w_fall, w_found, w_done_hit;
  logic             w_do_grant, w_release, w_timeout, w_budget_ok, w_to_fire, w_ov_set;

  // Edges come from the registered sample, so window opens one cycle after vblnk is first seen.
  assign w_rise     = r_vblnk_s & ~r_vblnk_d;
  assign w_fall     = ~r_vblnk_s & r_vblnk_d;
  assign w_done_hit = |(done & r_grant);

`ifdef VBLANK_ARB_TIMEOUT_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0] r_burst;
  logic [15:0]   r_budget;

  assign w_timeout   = (r_burst == BW'(MAX_BURST - 1));
  assign w_budget_ok = (r_budget >= 16'(MAX_BURST));

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_burst  <= '0;
      r_budget <= '0;
    end else begin
      if (w_do_grant)             r_burst <= '0;
      else if (r_state == S_GRANT) r_burst <= r_burst + 1'b1;
      if (w_rise)                           r_budget <= 16'(VBLANK_CYCLES);
      else if (r_window && r_budget != '0)  r_budget <= r_budget - 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_budget_ok  = 1'b1;
  // Burst and budget limits only shape the timeout build.
  assign w_unused_cfg = (MAX_BURST > 0) ^ (VBLANK_CYCLES > 0);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_release   = 1'b0;
    if (w_fall) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_rise) w_state_nxt = S_ARB;
        S_ARB:   if (w_found && w_budget_ok) begin
                   w_do_grant  = 1'b1;
                   w_state_nxt = S_GRANT;
                 end
        S_GRANT: if (w_done_hit || w_timeout) begin
                   w_release   = 1'b1;
                   w_state_nxt = S_GAP;
                 end
        S_GAP:   if (r_gap == GW'(GAP_CYCLES - 1)) w_state_nxt = S_ARB;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A completed burst wins over a simultaneous timeout; window close always reports a held grant.
  assign w_to_fire = (r_state == S_GRANT) && w_timeout && !w_done_hit;
  assign w_ov_set  = w_fall ? (|r_grant) : w_to_fire;

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vblnk_s <= 1'b0;
      r_vblnk_d <= 1'b0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_gap     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_window  <= 1'b0;
      r_tick    <= 1'b0;
      r_overrun <= 1'b0;
      r_ov_id   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_vblnk_s <= vblnk;
      r_vblnk_d <= r_vblnk_s;
      r_window  <= (w_state_nxt != S_IDLE);
      r_tick    <= (r_state == S_IDLE) && w_rise;
      r_gap     <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
      if (w_fall || w_release) begin
        r_grant <= '0;
        r_busy  <= 1'b0;
      end else if (w_do_grant) begin
        r_grant <= N_REQ'(1) << w_win;
        r_busy  <= 1'b1;
        r_owner <= w_win;
        r_ptr   <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (w_ov_set) begin
        r_overrun <= 1'b1;
        r_ov_id   <= 3'(r_owner);
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign grant      = r_grant;
  assign busy       = r_busy;
  assign window     = r_window;
  assign frame_tick = r_tick;
  assign overrun    = r_overrun;
  assign overrun_id = r_ov_id;

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// Self-checking bench for vblank_access_arbiter: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vblank_access_arbiter;

  localparam int NR  = 4;
  localparam int MB  = 16;
  localparam int VB  = 40;
  localparam int GAP = 2;
`ifdef VBLANK_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          rst, vblnk, overrun_clr;
  logic [NR-1:0] req, done, grant;
  logic          busy, window, frame_tick, overrun;
  logic [2:0]    overrun_id;

  int n_checks = 0;
  int n_err    = 0;
  bit auto_done = 1'b0;

  // Reference model: who owns the resource, and cycle stamps of window open / earliest next grant.
  int m_cyc = 0, m_owner = -1, m_ptr = 0, m_gstart = 0, m_open = 0, m_earliest = 0, m_id = 0;
  bit m_v1 = 0, m_v2 = 0, m_win = 0, m_tick = 0, m_ov = 0;

  int got_q[$];

  vblank_access_arbiter #(
    .N_REQ(NR), .MAX_BURST(MB), .VBLANK_CYCLES(VB), .GAP_CYCLES(GAP)
  ) dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .req(req), .done(done),
    .overrun_clr(overrun_clr), .grant(grant), .busy(busy), .window(window),
    .frame_tick(frame_tick), .overrun(overrun), .overrun_id(overrun_id)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rise, fall, set_ov;
    int sid;
    m_cyc++;
    if (rst) begin
      m_v1 = 0; m_v2 = 0; m_win = 0; m_tick = 0;
      m_owner = -1; m_ptr = 0; m_ov = 0; m_id = 0;
    end else begin
      rise = m_v1 && !m_v2;
      fall = !m_v1 && m_v2;
      set_ov = 0; sid = 0; m_tick = 0;
      if (fall) begin
        if (m_owner >= 0) begin set_ov = 1; sid = m_owner; end
        m_owner = -1; m_win = 0;
      end else if (rise && !m_win) begin
        m_win = 1; m_tick = 1; m_open = m_cyc; m_earliest = m_cyc + 1;
      end else if (m_win) begin
        if (m_owner >= 0) begin
          if (done[2'(m_owner)]) begin
            m_owner = -1; m_earliest = m_cyc + GAP + 1;
          end else if (TMO && (m_cyc - m_gstart == MB)) begin
            set_ov = 1; sid = m_owner; m_owner = -1; m_earliest = m_cyc + GAP + 1;
          end
        end else if (m_cyc >= m_earliest && req != '0 &&
                     (!TMO || (VB - (m_cyc - m_open - 1)) >= MB)) begin
          for (int k = 0; k < NR; k++)
            if (m_owner < 0 && req[2'((m_ptr + k) % NR)]) m_owner = (m_ptr + k) % NR;
          m_gstart = m_cyc;
          m_ptr    = (m_owner + 1) % NR;
        end
      end
      m_v2 = m_v1;
      m_v1 = vblnk;
      if (set_ov) begin m_ov = 1; m_id = sid; end
      else if (overrun_clr) m_ov = 0;
    end
  endtask

  task automatic compare();
    logic [NR-1:0] eg;
    eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    check("cmp_grant",      32'(grant),      32'(eg));
    check("cmp_busy",       32'(busy),       32'(m_owner >= 0));
    check("cmp_window",     32'(window),     32'(m_win));
    check("cmp_frame_tick", 32'(frame_tick), 32'(m_tick));
    check("cmp_overrun",    32'(overrun),    32'(m_ov));
    check("cmp_overrun_id", 32'(overrun_id), 32'(m_id));
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    compare();
    if (auto_done) done = grant;
  endtask

  task automatic step_rec();
    step();
    for (int k = 0; k < NR; k++) if (grant[k]) got_q.push_back(k);
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant == '0 && n < 10) begin
      step();
      n++;
    end
    check(name, 32'(grant != '0), 32'd1);
  endtask

  initial begin
    int exp_order[15] = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    int cnt;
    logic [NR-1:0] seen;

    rst = 1'b1; vblnk = 1'b0; req = '0; done = '0; overrun_clr = 1'b0;
    repeat (3) step();
    check("reset_grant",   32'(grant),   32'd0);
    check("reset_window",  32'(window),  32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    step();

    // Two requesters: index 0 first, index 2 after the gap.
    req = 4'b0101; vblnk = 1'b1;
    step();
    check("a_window_pre", 32'(window), 32'd0);
    step();
    check("a_tick",      32'(frame_tick), 32'd1);
    check("a_window",    32'(window),     32'd1);
    check("a_grant_t1",  32'(grant),      32'd0);
    step();
    check("a_tick_off",  32'(frame_tick), 32'd0);
    check("a_grant0",    32'(grant),      32'b0001);
    done = 4'b0001; step(); done = '0;
    check("a_release",   32'(grant), 32'd0);
    step(); step();
    check("a_gap",       32'(grant), 32'd0);
    step();
    check("a_grant2",    32'(grant), 32'b0100);
    done = 4'b0100; req = '0; step(); done = '0;
    vblnk = 1'b0;
    repeat (4) step();
    check("a_closed",    32'(window), 32'd0);

    // All four requesting, immediate done, three frames: rotation continues across frames.
    req = 4'b1111; auto_done = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      vblnk = 1'b1;
      repeat (20) step_rec();
      vblnk = 1'b0;
      repeat (4) step_rec();
    end
    auto_done = 1'b0; done = '0; req = '0;
    check("b_order_len", 32'(got_q.size()), 32'd15);
    for (int i = 0; i < 15; i++)
      check($sformatf("b_order_%0d", i),
            32'((i < got_q.size()) ? got_q[i] : -1), 32'(exp_order[i]));

    // Window closes while grant[1] is held.
    req = 4'b0010; vblnk = 1'b1;
    wait_grant("c_grant_seen");
    check("c_grant1", 32'(grant), 32'b0010);
    step(); step();
    vblnk = 1'b0;
    step();
    check("c_hold",       32'(grant),  32'b0010);
    check("c_window_hold", 32'(window), 32'd1);
    step();
    check("c_drop",       32'(grant),      32'd0);
    check("c_window_drop", 32'(window),    32'd0);
    check("c_overrun",    32'(overrun),    32'd1);
    check("c_overrun_id", 32'(overrun_id), 32'd1);
    req = '0; overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    check("c_overrun_clr", 32'(overrun), 32'd0);
    repeat (3) step();

`ifdef VBLANK_ARB_TIMEOUT_EN
    // Timeout: grant[2] held for exactly MB cycles, then overrun with id 2.
    vblnk = 1'b1; req = 4'b0100;
    wait_grant("d_grant_seen");
    req = '0;
    cnt = 0;
    for (int i = 0; i < 40 && grant[2]; i++) begin
      cnt++;
      step();
    end
    check("d_burst_len",  32'(cnt),        32'd16);
    check("d_overrun",    32'(overrun),    32'd1);
    check("d_overrun_id", 32'(overrun_id), 32'd2);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    check("d_overrun_clr", 32'(overrun), 32'd0);
    // Budget boundary: a late request in the same frame must wait for the next one.
    repeat (10) step();
    req = 4'b1000;
    seen = '0;
    repeat (8) begin
      step();
      seen |= grant;
    end
    check("d_budget_block", 32'(seen), 32'd0);
    vblnk = 1'b0;
    repeat (4) step();
    vblnk = 1'b1;
    wait_grant("d_next_frame_seen");
    check("d_next_frame", 32'(grant), 32'b1000);
    done = 4'b1000; req = '0; step(); done = '0;
    vblnk = 1'b0;
    repeat (4) step();
`endif

    // Reset mid-grant clears outputs and the round-robin pointer.
    vblnk = 1'b1; req = 4'b0010;
    wait_grant("e_grant_seen");
    step();
    rst = 1'b1;
    step();
    check("e_grant",   32'(grant),      32'd0);
    check("e_busy",    32'(busy),       32'd0);
    check("e_window",  32'(window),     32'd0);
    check("e_tick",    32'(frame_tick), 32'd0);
    check("e_overrun", 32'(overrun),    32'd0);
    check("e_ov_id",   32'(overrun_id), 32'd0);
    rst = 1'b0; vblnk = 1'b0; req = '0;
    repeat (3) step();
    req = 4'b0110; vblnk = 1'b1;
    step(); step(); step();
    check("e_grant_ptr0", 32'(grant), 32'b0010);
    done = 4'b0010; req = '0; step(); done = '0;
    vblnk = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
